// File: rtl/abc_sweep_pkg.sv
// Shared state encodings and sizing for the ABC truth-table sweep sequencer.
package abc_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned NUM_PATTERNS = 8;
  localparam int unsigned IDX_W        = 3;

  // Width of the per-pattern hold counter.
  function automatic int unsigned cnt_width(input int unsigned hold);
    return $clog2(hold);
  endfunction

endpackage

// File: rtl/abc_sweep_sequencer_if.sv
// Control, result and function-block signals of the sweep sequencer.
interface abc_sweep_sequencer_if;
  import abc_sweep_pkg::*;

  logic                    start;
  logic [NUM_PATTERNS-1:0] exp_table;
  logic                    A;
  logic                    B;
  logic                    C;
  logic                    E;
  logic                    busy;
  logic                    done;
  logic [NUM_PATTERNS-1:0] truth_table;
  logic                    pass;
  logic [NUM_PATTERNS-1:0] mismatch;

  // The sequencer side: drives the pattern and reports results.
  modport master (
    input  start, exp_table, E,
    output A, B, C, busy, done, truth_table, pass, mismatch
  );

  // The user / function-block side.
  modport slave (
    output start, exp_table, E,
    input  A, B, C, busy, done, truth_table, pass, mismatch
  );
endinterface

// File: rtl/hold_counter.sv
// Counts 0..HOLD_CYCLES-1 while enabled; o_wrap_c flags the last count of a hold period.
module hold_counter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_wrap_c
);
  import abc_sweep_pkg::*;

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign o_wrap_c  = i_en && w_at_last;

  // Count register: cleared outside a hold sequence, wraps after the last count.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_at_last) r_cnt <= '0;
      else           r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/abc_sweep_sequencer.sv
// Drives {A,B,C} through all 8 patterns, captures E into a truth table and compares it.
module abc_sweep_sequencer
  import abc_sweep_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  abc_sweep_sequencer_if.master sif
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [2:0]              r_abc;
  logic [2:0]              w_abc_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    r_pass;
  logic                    w_pass_nxt;
  logic [NUM_PATTERNS-1:0] r_exp;
  logic [NUM_PATTERNS-1:0] w_exp_nxt;
  logic [NUM_PATTERNS-1:0] r_tt;
  logic [NUM_PATTERNS-1:0] w_tt_nxt;
  logic [NUM_PATTERNS-1:0] r_mm;
  logic [NUM_PATTERNS-1:0] w_mm_nxt;
  logic                    w_wrap;
  logic                    w_in_drive;
  logic                    w_last_idx;

  assign w_in_drive = (r_state == ST_DRIVE);
  assign w_last_idx = (r_idx == IDX_W'(NUM_PATTERNS - 1));

  hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_in_drive),
    .i_en     (w_in_drive),
    .o_wrap_c (w_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (sif.start) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (w_wrap && w_last_idx) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_abc_nxt  = r_abc;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    w_exp_nxt  = r_exp;
    w_tt_nxt   = r_tt;
    w_pass_nxt = r_pass;
    w_mm_nxt   = r_mm;
    unique case (r_state)
      ST_IDLE: begin
        if (sif.start) begin
          w_idx_nxt  = '0;
          w_abc_nxt  = '0;
          w_busy_nxt = 1'b1;
          w_exp_nxt  = sif.exp_table;
          w_tt_nxt   = '0;
          w_pass_nxt = 1'b0;
          w_mm_nxt   = '0;
        end
      end
      ST_DRIVE: begin
        if (w_wrap) begin
          w_tt_nxt[r_idx] = sif.E;
          if (w_last_idx) begin
            // Compare against the table including this final sample.
            w_idx_nxt  = '0;
            w_abc_nxt  = '0;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
            w_pass_nxt = (w_tt_nxt == r_exp);
            w_mm_nxt   = w_tt_nxt ^ r_exp;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            w_abc_nxt = 3'(r_idx + IDX_W'(1));
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_abc  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_exp  <= '0;
      r_tt   <= '0;
      r_pass <= 1'b0;
      r_mm   <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_abc  <= w_abc_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_exp  <= w_exp_nxt;
      r_tt   <= w_tt_nxt;
      r_pass <= w_pass_nxt;
      r_mm   <= w_mm_nxt;
    end
  end

  assign sif.A           = r_abc[2];
  assign sif.B           = r_abc[1];
  assign sif.C           = r_abc[0];
  assign sif.busy        = r_busy;
  assign sif.done        = r_done;
  assign sif.truth_table = r_tt;
  assign sif.pass        = r_pass;
  assign sif.mismatch    = r_mm;

endmodule
